axis_subcarrier_extract: RTL

- Sits directly upstream of axis_demodulator. Consumes FFT output bins of one received DCO-OFDM symbol as a 48-bit complex AXI4-stream.
- Drops the DC bin and the Hermitian-mirror half, then forwards only the data subcarriers.
- Marks the last data subcarrier of each symbol with tlast, so the demodulator sees exactly one frame per OFDM symbol.
- One-stage registered output with full AXI4-stream backpressure.

---
 rtl/lifi_ofdm_pkg.sv | 25 ++
 rtl/axis_reg_slice.sv | 45 ++++
 rtl/axis_subcarrier_extract.sv | 108 ++++++++++
 3 files changed

// File: rtl/lifi_ofdm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : lifi_ofdm_pkg                                            |
// | Description : Shared widths, complex-sample field slices and default   |
// |               subcarrier map for the LiFi DCO-OFDM receive chain.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package lifi_ofdm_pkg;

  // Complex sample: [23:0] real, [47:24] imaginary, both signed
  localparam int CPLX_W  = 48;
  localparam int SAMP_W  = 24;

  localparam int RE_LSB  = 0;
  localparam int RE_MSB  = SAMP_W - 1;
  localparam int IM_LSB  = SAMP_W;
  localparam int IM_MSB  = CPLX_W - 1;

  // Default subcarrier map: DC bin dropped, upper Hermitian half dropped
  localparam int DEF_FFT_LEN   = 64;
  localparam int DEF_FIRST_BIN = 1;
  localparam int DEF_LAST_BIN  = 31;

endpackage : lifi_ofdm_pkg
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : axis_reg_slice                                           |
// | Description : One-deep registered AXI4-stream stage. Loads and drains  |
// |               in the same cycle, so it sustains one beat per cycle.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module axis_reg_slice
  import lifi_ofdm_pkg::*;
#(
  parameter int DATA_W = CPLX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Space exists when empty or when the held beat leaves this cycle
  assign o_s_ready = !r_valid || i_m_ready;
  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;

  // Load on upstream handshake; otherwise clear when the held beat drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_s_valid && o_s_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_s_data;
    end else if (i_m_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule : axis_reg_slice
`default_nettype wire

// File: rtl/axis_subcarrier_extract.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : axis_subcarrier_extract                                  |
// | Description : Forwards only the data subcarriers [FIRST_BIN..LAST_BIN] |
// |               of each FFT symbol and closes every symbol with tlast.   |
// |               Define SUBCARRIER_ERR_EN to add the saturating           |
// |               frame_err_cnt output (early / missing input tlast).      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module axis_subcarrier_extract
  import lifi_ofdm_pkg::*;
#(
  parameter int FFT_LEN   = DEF_FFT_LEN,
  parameter int FIRST_BIN = DEF_FIRST_BIN,
  parameter int LAST_BIN  = DEF_LAST_BIN,
  parameter int CNT_W     = $clog2(FFT_LEN)
) (
  input  logic              aclk,
  input  logic              aresetn,
  output logic              s_axis_tready,
  input  logic [CPLX_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CPLX_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              en
`ifdef SUBCARRIER_ERR_EN
  ,
  output logic [15:0]       frame_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(FIRST_BIN);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LAST_BIN);
  localparam logic [CNT_W-1:0] C_END   = CNT_W'(FFT_LEN - 1);

  logic [CNT_W-1:0]  r_bin_cnt;
  logic              w_in_win;
  logic              w_cnt_end;
  logic              w_slice_rdy;
  logic              w_hs_in;
  logic              w_load;
  logic              w_last_in;
  logic [CPLX_W:0]   w_m_data;

  assign w_in_win  = (r_bin_cnt >= C_FIRST) && (r_bin_cnt <= C_LAST);
  assign w_cnt_end = (r_bin_cnt == C_END);

  // Out-of-window bins are discarded, so only in-window bins wait for space
  assign s_axis_tready = en && (!w_in_win || w_slice_rdy);
  assign w_hs_in       = s_axis_tvalid && s_axis_tready;
  assign w_load        = w_hs_in && w_in_win;

  // An early input tlast inside the window closes the output frame there
  assign w_last_in = (r_bin_cnt == C_LAST) || s_axis_tlast;

  // Bin position within the symbol; tlast or natural wrap restarts at 0
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_bin_cnt <= '0;
    end else if (w_hs_in) begin
      if (s_axis_tlast || w_cnt_end) begin
        r_bin_cnt <= '0;
      end else begin
        r_bin_cnt <= r_bin_cnt + 1'b1;
      end
    end
  end

  axis_reg_slice #(
    .DATA_W (CPLX_W + 1)
  ) u_out_slice (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_s_valid (w_load),
    .o_s_ready (w_slice_rdy),
    .i_s_data  ({w_last_in, s_axis_tdata}),
    .o_m_valid (m_axis_tvalid),
    .i_m_ready (m_axis_tready),
    .o_m_data  (w_m_data)
  );

  assign m_axis_tlast = w_m_data[CPLX_W];
  assign m_axis_tdata = w_m_data[CPLX_W-1:0];

`ifdef SUBCARRIER_ERR_EN
  logic [15:0] r_err_cnt;
  logic        w_frame_err;

  // Early tlast (tlast before the final bin) or missing tlast (none on it)
  assign w_frame_err = w_hs_in && (s_axis_tlast != w_cnt_end);

  // Saturating framing-error counter, cleared only by reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_err_cnt <= '0;
    end else if (w_frame_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_err_cnt = r_err_cnt;
`endif

endmodule : axis_subcarrier_extract
`default_nettype wire
